// File: rtl/chip8_mem_pkg.sv
// Shared types and helpers for the chip8 backing-RAM arbiter.
package chip8_mem_pkg;

  localparam int unsigned DefaultAddrW = 12;
  localparam int unsigned DefaultDataW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StAck
  } state_e;

  typedef enum logic {
    OpRead,
    OpWrite
  } op_e;

  // Index width that never collapses to zero, so a single-port build still has a 1-bit id.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Round-robin requestor selection; the search starts at the pointer and wraps.
module rr_arbiter
  import chip8_mem_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = clog2_min1(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic            advance_i,
  output logic [IdxW-1:0] grant_o,
  output logic            grant_valid_o
);

  logic [IdxW-1:0] ptr_q;
  int unsigned     cand;

  // First requester at or after the pointer, modulo N.
  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    cand          = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr_q) + i) % N;
      if (!grant_valid_o && req_i[cand[IdxW-1:0]]) begin
        grant_o       = cand[IdxW-1:0];
        grant_valid_o = 1'b1;
      end
    end
  end

  if (N == 1) begin : g_single
    // Only one port: the pointer never moves.
    assign ptr_q = '0;
  end else begin : g_multi
    logic [IdxW-1:0] ptr_d;

    // Move the pointer just past the winner on every accepted grant.
    always_comb begin
      ptr_d = ptr_q;
      if (advance_i && grant_valid_o) begin
        ptr_d = (32'(grant_o) == N - 1) ? '0 : grant_o + IdxW'(1);
      end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port round-robin arbiter in front of the single-port chip8 backing RAM.
module mem_arbiter
  import chip8_mem_pkg::*;
#(
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned ADDR_W     = DefaultAddrW,
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned RD_LATENCY = 1,
  localparam int unsigned GntW      = clog2_min1(N_PORTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        req_read,
  input  logic [N_PORTS-1:0]        req_write,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS*DATA_W-1:0] req_wdata,
  output logic [N_PORTS-1:0]        req_ack,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [GntW-1:0]           grant_id,
  output logic                      busy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("mem_arbiter: RD_LATENCY must be in 1..4");
  end
  if (N_PORTS < 1 || N_PORTS > 8) begin : g_bad_ports
    $error("mem_arbiter: N_PORTS must be in 1..8");
  end

  localparam logic [1:0] WaitInit = 2'(RD_LATENCY - 1);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [GntW-1:0]      gnt_q, gnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic                 busy_q, busy_d;
  logic [N_PORTS-1:0]   ack_q, ack_d;

  logic [N_PORTS-1:0]   req_any;
  logic [GntW-1:0]      arb_gnt;
  logic                 arb_valid;
  logic                 arb_advance;

  assign req_any     = req_read | req_write;
  assign arb_advance = (state_q == StIdle);

  rr_arbiter #(
    .N (N_PORTS)
  ) u_rr (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req_any),
    .advance_i     (arb_advance),
    .grant_o       (arb_gnt),
    .grant_valid_o (arb_valid)
  );

  // Transaction sequencing plus next values of every registered output.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          // A pending write on the winning port goes before its pending read.
          op_d    = req_write[arb_gnt] ? OpWrite : OpRead;
          addr_d  = req_addr[arb_gnt*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[arb_gnt*DATA_W +: DATA_W];
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = WaitInit;
        state_d = (op_q == OpWrite) ? StAck : StWait;
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          rdata_d = mem_rdata;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    mem_en_d = (state_d == StIssue);
    mem_we_d = (state_d == StIssue) && (op_d == OpWrite);
    busy_d   = (state_d != StIdle);
    ack_d    = '0;
    if (state_d == StAck) ack_d[gnt_d] = 1'b1;
  end

  // State and output registers; reset drops any in-flight access silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= OpRead;
      gnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
    end
  end

  assign req_ack   = ack_q;
  assign req_rdata = rdata_q;
  assign grant_id  = gnt_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int L  = 3;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_read, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ack;
  logic [DW-1:0]   req_rdata;
  logic [GW-1:0]   grant_id;
  logic            busy, mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  logic [AW-1:0]   port_addr [N];
  logic [DW-1:0]   port_data [N];

  // Environment RAM with an L-deep read pipeline; junk on non-read cycles.
  logic [DW-1:0]   ram [4096];
  logic [DW-1:0]   rd_pipe [L];
  logic            ram_init;

  // Reference model state.
  logic [DW-1:0]   model_mem [4096];
  int              mptr;
  int              gq[$];
  bit              oq[$];
  int              n_cmp, n_err;

  mem_arbiter #(
    .N_PORTS    (N),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RD_LATENCY (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_read  (req_read),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .req_rdata (req_rdata),
    .grant_id  (grant_id),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int p = 0; p < N; p++) begin
      req_addr[p*AW +: AW]  = port_addr[p];
      req_wdata[p*DW +: DW] = port_data[p];
    end
  end

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a) ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= pat(i);
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : DW'($urandom);
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[L-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model arbitration: first port holding any request, starting at the model pointer.
  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int p;
      p = (mptr + i) % N;
      if (req_read[p] || req_write[p]) return p;
    end
    return -1;
  endfunction

  task automatic new_req(input int p);
    int unsigned r;
    r = $urandom_range(0, 2);
    port_addr[p] = AW'(32'h100 + $urandom_range(0, 15));
    port_data[p] = DW'($urandom);
    req_read[p]  = (r != 1);
    req_write[p] = (r != 0);
  endtask

  // Serve requests until none remain or max_grants acks were seen. Called in an idle cycle
  // with the requests already applied; returns in the idle cycle after the last ack.
  task automatic run(input int max_grants, input logic [N-1:0] rereq, output int grants);
    int w, gap, issue_c;
    bit wr, first;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    grants = 0;
    first  = 1'b1;
    while (grants < max_grants) begin
      w = pick();
      if (w < 0) break;
      wr      = req_write[w];
      a       = port_addr[w];
      d       = port_data[w];
      issue_c = first ? 1 : 2;
      gap     = (wr ? 2 : 2 + L) + (first ? 0 : 1);
      for (int c = 1; c < gap; c++) begin
        tick();
        check("ack_early", req_ack, 0);
        check("busy", busy, (c >= issue_c) ? 1 : 0);
        if (c == issue_c) begin
          check("issue_en", mem_en, 1);
          check("issue_we", mem_we, wr);
          check("issue_addr", mem_addr, a);
          check("issue_gid", grant_id, w);
          if (wr) check("issue_wdata", mem_wdata, d);
        end else begin
          check("en_quiet", mem_en, 0);
        end
      end
      tick();
      check("ack", req_ack, 32'(1) << w);
      check("ack_gid", grant_id, w);
      if (wr) model_mem[a] = d;
      else    check("rdata", req_rdata, model_mem[a]);
      gq.push_back(w);
      oq.push_back(wr);
      if (wr) req_write[w] = 1'b0;
      else    req_read[w]  = 1'b0;
      if (rereq[w]) new_req(w);
      mptr   = (w + 1) % N;
      grants = grants + 1;
      first  = 1'b0;
    end
    if (grants > 0) begin
      req_read  = '0;
      req_write = '0;
      tick();
      check("idle_after", busy, 0);
    end
  endtask

  initial begin
    int g;
    n_cmp = 0;
    n_err = 0;
    mptr  = 0;
    req_read  = '0;
    req_write = '0;
    for (int p = 0; p < N; p++) begin
      port_addr[p] = '0;
      port_data[p] = '0;
    end
    for (int i = 0; i < 4096; i++) model_mem[i] = pat(i);
    ram_init = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    // Reset state.
    check("rst_ack", req_ack, 0);
    check("rst_rdata", req_rdata, 0);
    check("rst_gid", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_en", mem_en, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    ram_init = 1'b0;
    rst_n    = 1'b1;
    tick();

    // Port 0 write 0x200 <- 0xA5.
    port_addr[0] = 12'h200;
    port_data[0] = 8'hA5;
    req_write[0] = 1'b1;
    run(8, '0, g);
    check("a_grants", g, 1);

    // Port 1 reads it back.
    port_addr[1] = 12'h200;
    req_read[1]  = 1'b1;
    run(8, '0, g);
    check("b_rdata_const", req_rdata, 8'hA5);

    // Port 2 writes 0x0FF <- 0x3C, port 3 reads it; pointer then wraps to 0.
    port_addr[2] = 12'h0FF;
    port_data[2] = 8'h3C;
    req_write[2] = 1'b1;
    run(8, '0, g);
    port_addr[3] = 12'h0FF;
    req_read[3]  = 1'b1;
    gq.delete();
    run(8, '0, g);
    check("c_port3", gq[0], 3);
    check("c_rdata_const", req_rdata, 8'h3C);
    port_addr[1] = 12'h101;
    port_addr[2] = 12'h102;
    req_read[1]  = 1'b1;
    req_read[2]  = 1'b1;
    gq.delete();
    run(8, '0, g);
    check("c_wrap_first", gq[0], 1);

    // Request withdrawn right after the grant still completes with an ack.
    port_addr[2] = 12'h123;
    port_data[2] = 8'h77;
    req_write[2] = 1'b1;
    tick();
    check("d_en", mem_en, 1);
    check("d_addr", mem_addr, 12'h123);
    req_write[2] = 1'b0;
    tick();
    check("d_ack", req_ack, 4'b0100);
    model_mem[12'h123] = 8'h77;
    mptr = 3;
    tick();
    check("d_idle", busy, 0);

    // Reset during ISSUE: mem_en must fall without a clock edge.
    port_addr[0] = 12'h200;
    req_read[0]  = 1'b1;
    tick();
    check("e_en_before", mem_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("e_en_async", mem_en, 0);
    check("e_busy_async", busy, 0);
    req_read = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Reset during WAIT of a read moves the pointer back to 0 and loses the ack.
    req_read[0] = 1'b1;
    tick();
    tick();
    check("f_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("f_en_async", mem_en, 0);
    check("f_busy_async", busy, 0);
    req_read = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("f_no_ack", req_ack, 0);
      check("f_idle", busy, 0);
    end
    mptr = 0;

    // Port 0 read+write together, port 1 write: port0 W, port1 W, port0 R.
    port_addr[0] = 12'h140;
    port_data[0] = 8'h9E;
    req_read[0]  = 1'b1;
    req_write[0] = 1'b1;
    port_addr[1] = 12'h141;
    port_data[1] = 8'h11;
    req_write[1] = 1'b1;
    gq.delete();
    oq.delete();
    run(8, '0, g);
    check("g_count", g, 3);
    check("g_p0", gq[0], 0);
    check("g_p1", gq[1], 1);
    check("g_p2", gq[2], 0);
    check("g_o0", oq[0], 1);
    check("g_o1", oq[1], 1);
    check("g_o2", oq[2], 0);
    check("g_rdata_const", req_rdata, 8'h9E);

    // Ports 0 and 1 requesting continuously must alternate.
    new_req(0);
    new_req(1);
    gq.delete();
    run(8, 4'b0011, g);
    check("h_count", g, 8);
    check("h_first", gq[0], 1);
    for (int i = 1; i < gq.size(); i++) check("h_alternate", gq[i] != gq[i-1], 1);

    // Randomized traffic on all ports.
    for (int p = 0; p < N; p++) new_req(p);
    run(40, 4'b1111, g);
    check("r_count", g, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
